// File: rtl/tdm_demux_pkg.sv
// tdm_demux4 shared types and constants.
// Imported by the frame tracker and the demux top.
package tdm_demux_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial slot stream in, parallel lanes and status out.
// slave: the demux; master: the stream source / lane sink.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  import tdm_demux_pkg::*;

  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              frame_sync;
  logic [WIDTH-1:0]  d0;
  logic [WIDTH-1:0]  d1;
  logic [WIDTH-1:0]  d2;
  logic [WIDTH-1:0]  d3;
  logic              out_valid;
  logic              sync_err;
  logic              locked;
  logic [SLOT_W-1:0] slot;

  modport master (
    output din, din_valid, frame_sync,
    input  d0, d1, d2, d3,
    input  out_valid, sync_err, locked, slot
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output d0, d1, d2, d3,
    output out_valid, sync_err, locked, slot
  );
endinterface

// File: rtl/tdm_frame_tracker.sv
// Frame alignment FSM and slot counter for tdm_demux4.
// Emits staging write / lane capture strobes for the current beat.
module tdm_frame_tracker
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              frame_done,
  output logic              sync_err,
  output logic              wr_en,
  output logic [SLOT_W-1:0] wr_idx,
  output logic              cap
);

  state_t            state, nstate;
  logic [SLOT_W-1:0] nslot;
  logic              err;
  logic              hunt;
  logic              at0;
  logic              at_last;

  assign hunt    = (state == HUNT);
  assign at0     = (slot == SLOT_W'(0));
  assign at_last = (slot == SLOT_W'(NUM_SLOTS - 1));

  always_comb begin
    nstate = state;
    nslot  = slot;
    wr_en  = 1'b0;
    wr_idx = '0;
    cap    = 1'b0;
    err    = 1'b0;
    if (din_valid) begin
      unique case (1'b1)
        hunt && frame_sync: begin
          wr_en  = 1'b1;
          nslot  = SLOT_W'(1);
          nstate = LOCKED;
        end
        hunt && !frame_sync: begin
          nslot = '0;
        end
        !hunt && frame_sync: begin
          // early sync restarts the frame here
          err   = !at0;
          wr_en = 1'b1;
          nslot = SLOT_W'(1);
        end
        !hunt && !frame_sync && at0: begin
          err    = 1'b1;
          nstate = HUNT;
          nslot  = '0;
        end
        !hunt && !frame_sync && at_last: begin
          cap   = 1'b1;
          nslot = '0;
        end
        !hunt && !frame_sync && !at0 && !at_last: begin
          wr_en  = 1'b1;
          wr_idx = slot;
          nslot  = slot + SLOT_W'(1);
        end
        default: begin
          nslot = slot;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= nstate;
      slot       <= nslot;
      frame_done <= cap;
      sync_err   <= err;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer: serial slot words to parallel lanes.
// Slots 0..2 are staged; the slot-3 beat publishes all four lanes.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);

  logic [WIDTH-1:0]  stage [NUM_SLOTS-1];
  logic [WIDTH-1:0]  d0_q, d1_q, d2_q, d3_q;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_idx;
  logic              cap;
  logic              frame_done;
  logic              sync_err;
  logic              locked;
  logic [SLOT_W-1:0] slot;

  tdm_frame_tracker u_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (bus.din_valid),
    .frame_sync (bus.frame_sync),
    .slot       (slot),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .cap        (cap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++)
        stage[i] <= '0;
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS - 1; i++)
        if (wr_en && wr_idx == SLOT_W'(i))
          stage[i] <= bus.din;
      // lanes only ever move together
      if (cap) begin
        d0_q <= stage[0];
        d1_q <= stage[1];
        d2_q <= stage[2];
        d3_q <= bus.din;
      end
    end
  end

  assign bus.d0        = d0_q;
  assign bus.d1        = d1_q;
  assign bus.d2        = d2_q;
  assign bus.d3        = d3_q;
  assign bus.out_valid = frame_done;
  assign bus.sync_err  = sync_err;
  assign bus.locked    = locked;
  assign bus.slot      = slot;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=4).
// Inputs change #1 after posedge; outputs sampled there too.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tdm_demux4_if #(.WIDTH(4)) bus ();

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic [3:0] d, input logic fs);
    bus.din        = d;
    bus.frame_sync = fs;
    bus.din_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic idle();
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] lanes();
    return {bus.d0, bus.d1, bus.d2, bus.d3};
  endfunction

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.din        = 4'hF;
    bus.din_valid  = 1'b1;
    bus.frame_sync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_lanes", 32'(lanes()), 32'h0);
    chk("rst_ov", 32'(bus.out_valid), 32'h0);
    chk("rst_err", 32'(bus.sync_err), 32'h0);
    chk("rst_lock", 32'(bus.locked), 32'h0);
    chk("rst_slot", 32'(bus.slot), 32'h0);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n          = 1'b1;
  endtask

  task automatic test_lock();
    beat(4'hA, 1'b1);
    chk("lock_a_lock", 32'(bus.locked), 32'h1);
    chk("lock_a_slot", 32'(bus.slot), 32'h1);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    chk("lock_c_ov", 32'(bus.out_valid), 32'h0);
    chk("lock_c_lanes", 32'(lanes()), 32'h0);
    beat(4'hD, 1'b0);
    chk("lock_lanes", 32'(lanes()), 32'hABCD);
    chk("lock_ov", 32'(bus.out_valid), 32'h1);
    chk("lock_locked", 32'(bus.locked), 32'h1);
    chk("lock_slot", 32'(bus.slot), 32'h0);
    idle();
    chk("lock_ov_pulse", 32'(bus.out_valid), 32'h0);
    chk("lock_hold", 32'(lanes()), 32'hABCD);
  endtask

  task automatic test_idle_gaps();
    beat(4'h1, 1'b1);
    idle();
    chk("gap_slot1", 32'(bus.slot), 32'h1);
    beat(4'h2, 1'b0);
    idle();
    idle();
    chk("gap_slot2", 32'(bus.slot), 32'h2);
    beat(4'h3, 1'b0);
    idle();
    chk("gap_ov0", 32'(bus.out_valid), 32'h0);
    chk("gap_hold", 32'(lanes()), 32'hABCD);
    beat(4'h4, 1'b0);
    chk("gap_lanes", 32'(lanes()), 32'h1234);
    chk("gap_ov", 32'(bus.out_valid), 32'h1);
  endtask

  task automatic test_back_to_back();
    beat(4'h5, 1'b1);
    chk("b2b_ov5", 32'(bus.out_valid), 32'h0);
    beat(4'h6, 1'b0);
    beat(4'h7, 1'b0);
    chk("b2b_hold", 32'(lanes()), 32'h1234);
    beat(4'h8, 1'b0);
    chk("b2b_lanes", 32'(lanes()), 32'h5678);
    chk("b2b_ov", 32'(bus.out_valid), 32'h1);
    beat(4'h9, 1'b1);
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    chk("b2b2_lanes", 32'(lanes()), 32'h9ABC);
    chk("b2b2_ov", 32'(bus.out_valid), 32'h1);
  endtask

  task automatic test_hunt();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    beat(4'h9, 1'b0);
    chk("hunt_err1", 32'(bus.sync_err), 32'h0);
    beat(4'h9, 1'b0);
    chk("hunt_err2", 32'(bus.sync_err), 32'h0);
    chk("hunt_lock", 32'(bus.locked), 32'h0);
    chk("hunt_slot", 32'(bus.slot), 32'h0);
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    chk("hunt_ov0", 32'(bus.out_valid), 32'h0);
    beat(4'h4, 1'b0);
    chk("hunt_lanes", 32'(lanes()), 32'h1234);
    chk("hunt_ov", 32'(bus.out_valid), 32'h1);
  endtask

  task automatic test_early_sync();
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b1);
    chk("early_err", 32'(bus.sync_err), 32'h1);
    chk("early_ov", 32'(bus.out_valid), 32'h0);
    chk("early_hold", 32'(lanes()), 32'h1234);
    chk("early_slot", 32'(bus.slot), 32'h1);
    chk("early_lock", 32'(bus.locked), 32'h1);
    beat(4'h4, 1'b0);
    chk("early_errpulse", 32'(bus.sync_err), 32'h0);
    beat(4'h5, 1'b0);
    beat(4'h6, 1'b0);
    chk("early_lanes", 32'(lanes()), 32'h3456);
    chk("early_ov2", 32'(bus.out_valid), 32'h1);
  endtask

  task automatic test_missing_sync();
    beat(4'h7, 1'b0);
    chk("miss_err", 32'(bus.sync_err), 32'h1);
    chk("miss_lock", 32'(bus.locked), 32'h0);
    chk("miss_slot", 32'(bus.slot), 32'h0);
    chk("miss_ov", 32'(bus.out_valid), 32'h0);
    idle();
    chk("miss_errpulse", 32'(bus.sync_err), 32'h0);
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    beat(4'hD, 1'b0);
    chk("miss_lanes", 32'(lanes()), 32'hABCD);
    chk("miss_relock", 32'(bus.locked), 32'h1);
  endtask

  task automatic test_reset_mid();
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    rst_n = 1'b0;
    beat(4'h3, 1'b0);
    chk("rmid_lanes", 32'(lanes()), 32'h0);
    chk("rmid_lock", 32'(bus.locked), 32'h0);
    chk("rmid_slot", 32'(bus.slot), 32'h0);
    rst_n = 1'b1;
    beat(4'h4, 1'b0);
    chk("rmid_ov", 32'(bus.out_valid), 32'h0);
    chk("rmid_lock2", 32'(bus.locked), 32'h0);
    chk("rmid_lanes2", 32'(lanes()), 32'h0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    test_reset();
    test_lock();
    test_idle_gaps();
    test_back_to_back();
    test_hunt();
    test_early_sync();
    test_missing_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
